id_stage_ctl: RTL and testbench
===============================

Name: id_stage_ctl

Overview:
Decode-stage controller that sequences the immediate extender between the fetch and execute pipeline stages.
- Accepts instructions from IF over a valid/ready handshake and classifies each opcode into an IMM_* format code.
- Drives the immediate extender (instantiated internally, fed instr[31:7]) and registers the ID/EX payload.
- Inserts a single-cycle bubble on load-use hazards, honours flushes, and keeps a saturating bubble counter.

Parameters:
PC_W, 32, width of the program counter carried with each instruction
CNT_W, 16, width of the saturating bubble counter

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  IF presents an instruction
o_ready  output  1  ID accepts the instruction this cycle (combinational)
i_instr  input  32  instruction word
i_pc  input  PC_W  instruction address
i_flush  input  1  kill the held instruction and the incoming one (taken branch/jump)
o_valid  output  1  ID/EX payload is valid
i_ready  input  1  EX consumes the payload this cycle
o_instr  output  32  registered instruction
o_pc  output  PC_W  registered PC
o_imm  output  32  registered extended immediate
o_imm_ctl  output  3  registered IMM_* format code from Constants.vh
o_rs1, o_rs2, o_rd  output  5 each  registered register fields
o_is_load  output  1  registered: opcode 0000011
o_illegal  output  1  registered: opcode not in decode table
o_bubble_cnt  output  CNT_W  number of hazard bubbles inserted, saturating

Behaviour:
- Reset (async, i_rst_n=0): all registered outputs are 0, including o_valid, o_bubble_cnt, o_imm_ctl and the payload. o_ready is 0 while reset is asserted. Release is effective on the next edge.
- Opcode decode (i_instr[6:0]):
  - 0010011, 0000011, 1100111 → IMM_I_TYPE
  - 0100011 → IMM_S_TYPE
  - 1100011 → IMM_B_TYPE
  - 1101111 → IMM_J_TYPE
  - 0110111, 0010111 → IMM_U_TYPE
  - 0110011 → no immediate: o_imm=0, o_imm_ctl=0
  - Any other opcode → o_illegal=1, o_imm=0, o_imm_ctl=0
- Register usage:
  - uses_rs1 is 0 for the U and J formats and 1 otherwise.
  - uses_rs2 is 1 for the S, B and 0110011 formats only.
- Slot advance: adv = !o_valid || i_ready.
- Hazard: hazard = o_valid && o_is_load && o_rd!=0 && i_valid && ((uses_rs1 && rs1==o_rd) || (uses_rs2 && rs2==o_rd)), where rs1/rs2 are the incoming instruction's fields.
- Ready: o_ready = adv && !hazard && !i_flush. Accept = i_valid && o_ready.
- Latency: 1 cycle. An accepted instruction appears on o_* at the next edge with o_valid=1, and the immediate is registered in the same cycle.
- Each edge:
  - If i_flush: o_valid<=0; the payload may keep stale values.
  - Else if adv and Accept: load the payload, o_valid<=1.
  - Else if adv: o_valid<=0 (bubble or empty).
  - Else: hold all outputs stable.
- Hold rule: while o_valid && !i_ready, every o_* output is bit-stable.
- Bubble count: o_bubble_cnt increments by 1 on each edge where adv && hazard && !i_flush. It saturates at all-ones with no wrap.
- Load-use stall length: exactly one bubble. After the load leaves, the slot is empty, so o_is_load no longer qualifies and the dependent instruction is accepted the following cycle.
- When the held load has i_ready=0, the hazard stall simply extends; this adds no extra counts beyond the single bubble on the advancing edge.
- Flush: i_flush dominates hazard and accept, it is not counted as a bubble, and it takes effect in one cycle.
- Simultaneous flush and i_ready=0: the payload is still dropped; EX must not rely on the killed payload.
- rd=x0 loads never cause a stall.
- Reset asserted mid-stall clears state immediately, with no partial update.

Test Plan:
1. Reset → all outputs 0. Then addi x1,x0,-1 (0xFFF00093) with i_valid=1, i_ready=1 → next cycle o_valid=1, o_imm=0xFFFFFFFF, o_imm_ctl=IMM_I_TYPE, o_rd=1.
2. Back-to-back lui x1,0x12345 (0x123450B7), beq x0,x0,8 (0x00000463), jal x0,-4 (0xFFDFF06F):
   - o_imm sequence is 0x12345000, 0x00000008, 0xFFFFFFFC.
   - o_imm_ctl sequence is U, B, J.
   - One instruction per cycle, o_ready constantly 1.
3. lw x5,0(x2) (0x00012283) followed by add x6,x5,x1 (0x00128333):
   - o_ready=0 for exactly one cycle.
   - One o_valid=0 cycle appears between lw and add.
   - o_bubble_cnt=1.
   - Same sequence with rd=x0 → no stall, count unchanged.
4. Backpressure: i_ready=0 for 3 cycles with a valid payload → outputs stable, o_ready=0. Releasing i_ready → the next instruction follows 1 cycle later and none is lost or duplicated.
5. Flush: held valid payload plus a pending incoming instruction, with i_flush=1 for one cycle → o_ready=0 that cycle, o_valid=0 next cycle, o_bubble_cnt unchanged. An illegal opcode 0x0000007F afterwards → o_illegal=1, o_imm=0.
6. Async reset pulse mid-stall (between lw and add) → outputs zero without a clock edge. After release the stream restarts cleanly; force the counter near max to check saturation at all-ones.

Source files
------------

// File: rtl/id_stage_ctl.sv
// Decode-stage controller: classifies the incoming opcode, drives the
// immediate extender and holds a one-deep ID/EX slot with load-use bubbles.

// Immediate extender; takes instr[31:7], so bit k of the word is i_bits[k-7].
module id_stage_imm_ext (
    input  logic [24:0] i_bits,
    input  logic [2:0]  i_ctl,
    output logic [31:0] o_imm
);
    localparam logic [2:0] IMM_I_TYPE = 3'd1;
    localparam logic [2:0] IMM_S_TYPE = 3'd2;
    localparam logic [2:0] IMM_B_TYPE = 3'd3;
    localparam logic [2:0] IMM_U_TYPE = 3'd4;
    localparam logic [2:0] IMM_J_TYPE = 3'd5;

    // Reassemble the immediate for the selected format; no-immediate yields 0.
    always_comb begin
        o_imm = 32'd0;
        case (i_ctl)
            IMM_I_TYPE: o_imm = {{20{i_bits[24]}}, i_bits[24:13]};
            IMM_S_TYPE: o_imm = {{20{i_bits[24]}}, i_bits[24:18], i_bits[4:0]};
            IMM_B_TYPE: o_imm = {{19{i_bits[24]}}, i_bits[24], i_bits[0],
                                 i_bits[23:18], i_bits[4:1], 1'b0};
            IMM_U_TYPE: o_imm = {i_bits[24:5], 12'd0};
            IMM_J_TYPE: o_imm = {{11{i_bits[24]}}, i_bits[24], i_bits[12:5],
                                 i_bits[13], i_bits[23:14], 1'b0};
            default:    o_imm = 32'd0;
        endcase
    end
endmodule

module id_stage_ctl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_instr,
    output logic [PC_W-1:0]  o_pc,
    output logic [31:0]      o_imm,
    output logic [2:0]       o_imm_ctl,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_rd,
    output logic             o_is_load,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_bubble_cnt
);
    localparam logic [2:0] IMM_NONE   = 3'd0;
    localparam logic [2:0] IMM_I_TYPE = 3'd1;
    localparam logic [2:0] IMM_S_TYPE = 3'd2;
    localparam logic [2:0] IMM_B_TYPE = 3'd3;
    localparam logic [2:0] IMM_U_TYPE = 3'd4;
    localparam logic [2:0] IMM_J_TYPE = 3'd5;

    logic [6:0]  w_opc;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [2:0]  w_imm_ctl;
    logic [31:0] w_imm;
    logic        w_illegal, w_is_load, w_uses_rs1, w_uses_rs2;
    logic        w_hazard, w_adv, w_accept;

    assign w_opc     = i_instr[6:0];
    assign w_rs1     = i_instr[19:15];
    assign w_rs2     = i_instr[24:20];
    assign w_rd      = i_instr[11:7];
    assign w_is_load = (w_opc == 7'b0000011);

    // Opcode classification and source-register usage of the incoming word.
    always_comb begin
        w_imm_ctl  = IMM_NONE;
        w_illegal  = 1'b0;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        case (w_opc)
            7'b0010011, 7'b0000011, 7'b1100111: w_imm_ctl = IMM_I_TYPE;
            7'b0100011: begin w_imm_ctl = IMM_S_TYPE; w_uses_rs2 = 1'b1; end
            7'b1100011: begin w_imm_ctl = IMM_B_TYPE; w_uses_rs2 = 1'b1; end
            7'b1101111: begin w_imm_ctl = IMM_J_TYPE; w_uses_rs1 = 1'b0; end
            7'b0110111, 7'b0010111: begin w_imm_ctl = IMM_U_TYPE; w_uses_rs1 = 1'b0; end
            7'b0110011: w_uses_rs2 = 1'b1;
            default:    w_illegal = 1'b1;
        endcase
    end

    id_stage_imm_ext u_imm_ext (
        .i_bits (i_instr[31:7]),
        .i_ctl  (w_imm_ctl),
        .o_imm  (w_imm)
    );

    // A held load whose rd feeds the incoming instruction forces one bubble.
    assign w_hazard = o_valid && o_is_load && (o_rd != 5'd0) && i_valid &&
                      ((w_uses_rs1 && (w_rs1 == o_rd)) || (w_uses_rs2 && (w_rs2 == o_rd)));
    assign w_adv    = !o_valid || i_ready;
    assign o_ready  = i_rst_n && w_adv && !w_hazard && !i_flush;
    assign w_accept = i_valid && o_ready;

    // ID/EX slot: flush kills it, an advancing slot reloads or empties, else it holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_instr   <= 32'd0;
            o_pc      <= '0;
            o_imm     <= 32'd0;
            o_imm_ctl <= IMM_NONE;
            o_rs1     <= 5'd0;
            o_rs2     <= 5'd0;
            o_rd      <= 5'd0;
            o_is_load <= 1'b0;
            o_illegal <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (w_adv) begin
            o_valid <= w_accept;
            if (w_accept) begin
                o_instr   <= i_instr;
                o_pc      <= i_pc;
                o_imm     <= w_imm;
                o_imm_ctl <= w_imm_ctl;
                o_rs1     <= w_rs1;
                o_rs2     <= w_rs2;
                o_rd      <= w_rd;
                o_is_load <= w_is_load;
                o_illegal <= w_illegal;
            end
        end
    end

    // Count only the advancing edge of a stall, so a backpressured load adds nothing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_bubble_cnt <= '0;
        else if (!i_flush && w_adv && w_hazard && (o_bubble_cnt != {CNT_W{1'b1}}))
            o_bubble_cnt <= o_bubble_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_stage_ctl.sv
// Scoreboard bench for id_stage_ctl: directed scenarios plus random traffic,
// checked against a format-level reference model.
module tb_id_stage_ctl;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
    logic [31:0]      i_instr = 32'd0;
    logic [PC_W-1:0]  i_pc = '0;
    logic             o_ready, o_valid, o_is_load, o_illegal;
    logic [31:0]      o_instr, o_imm;
    logic [PC_W-1:0]  o_pc;
    logic [2:0]       o_imm_ctl;
    logic [4:0]       o_rs1, o_rs2, o_rd;
    logic [CNT_W-1:0] o_bubble_cnt;

    id_stage_ctl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc), .o_imm(o_imm),
        .o_imm_ctl(o_imm_ctl), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_is_load(o_is_load), .o_illegal(o_illegal), .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [31:0]     imm;
        logic [2:0]      ctl;
        logic [4:0]      rs1, rs2, rd;
        logic            ld, ill;
    } pl_t;

    pl_t q[$];
    int  errs = 0, checks = 0;
    int  m_cnt = 0;
    bit  m_valid = 0, m_ld = 0;
    logic [4:0] m_rd = 5'd0;
    logic [PC_W-1:0] pc_ctr = '0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Format codes: 0 none/illegal, 1 I, 2 S, 3 B, 4 U, 5 J
    function automatic logic [2:0] ref_fmt(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67: return 3'd1;
            7'h23:               return 3'd2;
            7'h63:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            7'h6F:               return 3'd5;
            default:             return 3'd0;
        endcase
    endfunction

    function automatic bit ref_ill(input logic [6:0] op);
        return !(op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33});
    endfunction

    // Immediate as a weighted sum of instruction fields, sign bit carrying negative weight.
    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        int v;
        int s;
        s = x[31] ? 1 : 0;
        case (ref_fmt(x[6:0]))
            3'd1: v = int'(x[30:20]) - s * 2048;
            3'd2: v = int'(x[30:25]) * 32 + int'(x[11:7]) - s * 2048;
            3'd3: v = int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2 - s * 4096;
            3'd4: v = int'(x[31:12]) * 4096;
            3'd5: v = int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2 - s * 1048576;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic pl_t dut_pl();
        return {o_instr, o_pc, o_imm, o_imm_ctl, o_rs1, o_rs2, o_rd, o_is_load, o_illegal};
    endfunction

    // Reference model: tracks the slot, predicts ready/valid/count, pushes expected payloads
    always @(negedge clk) begin : mdl
        logic [2:0] f;
        logic [4:0] rs1, rs2;
        bit u1, u2, haz, adv, rdy;
        pl_t e;
        if (!rst_n) begin
            m_valid = 0; m_ld = 0; m_rd = 5'd0; m_cnt = 0;
            q.delete();
        end else begin
            chk("o_valid", o_valid, m_valid);
            chk("o_bubble_cnt", o_bubble_cnt, m_cnt[CNT_W-1:0]);
            f   = ref_fmt(i_instr[6:0]);
            rs1 = i_instr[19:15];
            rs2 = i_instr[24:20];
            u1  = !(f == 3'd4 || f == 3'd5);
            u2  = (f == 3'd2 || f == 3'd3 || i_instr[6:0] == 7'h33);
            haz = m_valid && m_ld && m_rd != 5'd0 && i_valid &&
                  ((u1 && rs1 == m_rd) || (u2 && rs2 == m_rd));
            adv = !m_valid || i_ready;
            rdy = adv && !haz && !i_flush;
            chk("o_ready", o_ready, rdy);
            if (m_valid && !i_ready && q.size() > 0)
                chk("hold", dut_pl(), q[0]);
            if (i_flush) begin
                if (m_valid && q.size() > 0) void'(q.pop_front());
                m_valid = 0;
            end else if (adv) begin
                if (i_valid && rdy) begin
                    e.instr = i_instr; e.pc = i_pc; e.imm = ref_imm(i_instr);
                    e.ctl = f; e.rs1 = rs1; e.rs2 = rs2; e.rd = i_instr[11:7];
                    e.ld = (i_instr[6:0] == 7'h03); e.ill = ref_ill(i_instr[6:0]);
                    q.push_back(e);
                    m_valid = 1; m_ld = e.ld; m_rd = e.rd;
                end else begin
                    m_valid = 0;
                end
                if (haz && m_cnt < CNT_MX) m_cnt++;
            end
        end
    end

    // Monitor: every payload EX consumes must be the next expected one
    always @(negedge clk) begin : mon
        pl_t e;
        if (rst_n && o_valid && i_ready && !i_flush) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                e = q.pop_front();
                chk("payload", dut_pl(), e);
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
        i_valid = v; i_instr = ins; i_pc = pc_ctr; pc_ctr += 4;
        i_ready = rdy; i_flush = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] ADDI_M1 = 32'hFFF00093, LUI = 32'h123450B7,
        BEQ = 32'h00000463, JAL = 32'hFFDFF06F, LW5 = 32'h00012283,
        ADD6 = 32'h00128333, LW0 = 32'h00012003, ADD6X0 = 32'h00100333,
        INS_A = 32'h00500113, INS_B = 32'h00A00193, ILL = 32'h0000007F;

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_payload", {dut_pl(), o_valid, o_bubble_cnt}, 0);
        chk("reset_ready", o_ready, 0);
        rst_n = 1'b1;

        // basic I-type
        drive(1, ADDI_M1, 1, 0); step();
        chk("t1_valid", o_valid, 1); chk("t1_imm", o_imm, 32'hFFFFFFFF);
        chk("t1_ctl", o_imm_ctl, 3'd1); chk("t1_rd", o_rd, 5'd1);

        // back-to-back U, B, J
        drive(1, LUI, 1, 0); chk("t2_rdy0", o_ready, 1); step();
        chk("t2_imm_u", o_imm, 32'h12345000); chk("t2_ctl_u", o_imm_ctl, 3'd4);
        drive(1, BEQ, 1, 0); chk("t2_rdy1", o_ready, 1); step();
        chk("t2_imm_b", o_imm, 32'h00000008); chk("t2_ctl_b", o_imm_ctl, 3'd3);
        drive(1, JAL, 1, 0); chk("t2_rdy2", o_ready, 1); step();
        chk("t2_imm_j", o_imm, 32'hFFFFFFFC); chk("t2_ctl_j", o_imm_ctl, 3'd5);

        // load-use: one bubble, then rd=x0 load: none
        drive(1, LW5, 1, 0); step();
        drive(1, ADD6, 1, 0); chk("t3_stall", o_ready, 0); step();
        chk("t3_bubble", o_valid, 0); chk("t3_cnt", o_bubble_cnt, 1);
        drive(1, ADD6, 1, 0); chk("t3_retry", o_ready, 1); step();
        chk("t3_add_rd", o_rd, 5'd6); chk("t3_add_v", o_valid, 1);
        drive(1, LW0, 1, 0); step();
        drive(1, ADD6X0, 1, 0); chk("t3_x0_rdy", o_ready, 1); step();
        chk("t3_x0_cnt", o_bubble_cnt, 1); chk("t3_x0_v", o_valid, 1);

        // backpressure
        drive(1, INS_A, 1, 0); step();
        drive(1, INS_B, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_rdy", o_ready, 0); chk("t4_hold", o_instr, INS_A); step();
        end
        drive(1, INS_B, 1, 0); step();
        chk("t4_next", o_instr, INS_B);

        // flush with held payload and pending incoming, then illegal opcode
        drive(1, INS_A, 1, 0); step();
        drive(1, INS_B, 0, 1); chk("t5_rdy", o_ready, 0); step();
        chk("t5_valid", o_valid, 0); chk("t5_cnt", o_bubble_cnt, 1);
        drive(1, ILL, 1, 0); step();
        chk("t5_ill", o_illegal, 1); chk("t5_imm", o_imm, 0);
        drive(0, 32'd0, 1, 0); step();

        // random traffic, small register numbers to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            drive($urandom_range(0, 3) != 0,
                  {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   3'($urandom), 5'($urandom_range(0, 3)), op},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            step();
        end

        // async reset in the middle of a load-use stall
        drive(1, LW5, 1, 0); step();
        drive(1, ADD6, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async", {dut_pl(), o_valid, o_bubble_cnt}, 0);
        chk("t6_rdy", o_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1, ADDI_M1, 1, 0); step();
        chk("t6_restart_v", o_valid, 1); chk("t6_restart_imm", o_imm, 32'hFFFFFFFF);

        // saturation of the bubble counter
        for (int i = 0; i < CNT_MX + 5; i++) begin
            drive(1, LW5, 1, 0); step();
            drive(1, ADD6, 1, 0); step();
            drive(1, ADD6, 1, 0); step();
        end
        chk("t6_sat", o_bubble_cnt, 4'hF);
        drive(0, 32'd0, 1, 0); step(); step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
